// File: rtl/vga_sync_generator.sv
// VGA raster timing with a pixel-tick divider and a one-tick output register for colour and sync.
// Optional feature: define VGA_FRAME_COUNT_EN to add the 16-bit frame_count_out port.
module vga_sync_generator #(
  parameter int WIDTH_BITS    = 10,
  parameter int HEIGHT_BITS   = 10,
  parameter int CLOCK_DIVIDER = 2,
  parameter int H_DISPLAY     = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_DISPLAY     = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33
) (
`ifdef VGA_FRAME_COUNT_EN
  output logic [15:0]            frame_count_out,
`endif
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic [3:0]             pixel_red_in,
  input  logic [3:0]             pixel_green_in,
  input  logic [3:0]             pixel_blue_in,
  output logic [WIDTH_BITS-1:0]  pixel_x_out,
  output logic [HEIGHT_BITS-1:0] pixel_y_out,
  output logic                   pixel_tick_out,
  output logic                   video_on_out,
  output logic                   frame_start_out,
  output logic                   h_sync_out,
  output logic                   v_sync_out,
  output logic [3:0]             vga_red_out,
  output logic [3:0]             vga_green_out,
  output logic [3:0]             vga_blue_out
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;

  localparam logic [DIV_W-1:0]       DIV_LAST = DIV_W'(CLOCK_DIVIDER - 1);
  localparam logic [WIDTH_BITS-1:0]  X_LAST   = WIDTH_BITS'(H_TOTAL - 1);
  localparam logic [WIDTH_BITS-1:0]  X_VIS    = WIDTH_BITS'(H_DISPLAY);
  localparam logic [WIDTH_BITS-1:0]  HS_FIRST = WIDTH_BITS'(H_DISPLAY + H_FRONT);
  localparam logic [WIDTH_BITS-1:0]  HS_LAST  = WIDTH_BITS'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [HEIGHT_BITS-1:0] Y_LAST   = HEIGHT_BITS'(V_TOTAL - 1);
  localparam logic [HEIGHT_BITS-1:0] Y_VIS    = HEIGHT_BITS'(V_DISPLAY);
  localparam logic [HEIGHT_BITS-1:0] VS_FIRST = HEIGHT_BITS'(V_DISPLAY + V_FRONT);
  localparam logic [HEIGHT_BITS-1:0] VS_LAST  = HEIGHT_BITS'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  function automatic logic [3:0] blank(input logic [3:0] colour, input logic on);
    return on ? colour : 4'h0;
  endfunction

  logic [DIV_W-1:0]       div_p0;
  logic [WIDTH_BITS-1:0]  x_p0;
  logic [HEIGHT_BITS-1:0] y_p0;
  logic                   vld_p0;
  logic                   x_last_p0;
  logic                   y_last_p0;
  logic                   video_on_p0;
  logic                   hs_n_p0;
  logic                   vs_n_p0;

  // Stage p0: divider and raster counters; vld_p0 is the pixel tick
  assign vld_p0      = (div_p0 == DIV_LAST);
  assign x_last_p0   = (x_p0 == X_LAST);
  assign y_last_p0   = (y_p0 == Y_LAST);
  assign video_on_p0 = (x_p0 < X_VIS) && (y_p0 < Y_VIS);
  assign hs_n_p0     = !((x_p0 >= HS_FIRST) && (x_p0 <= HS_LAST));
  assign vs_n_p0     = !((y_p0 >= VS_FIRST) && (y_p0 <= VS_LAST));

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      div_p0 <= '0;
      x_p0   <= '0;
      y_p0   <= '0;
    end else begin
      if (vld_p0) div_p0 <= '0;
      else        div_p0 <= div_p0 + 1'b1;
      if (vld_p0) begin
        if (x_last_p0) begin
          x_p0 <= '0;
          if (y_last_p0) y_p0 <= '0;
          else           y_p0 <= y_p0 + 1'b1;
        end else begin
          x_p0 <= x_p0 + 1'b1;
        end
      end
    end
  end

  // Stage p1: connector register, loaded once per tick so colour and sync stay aligned
  logic       hs_n_p1;
  logic       vs_n_p1;
  logic [3:0] red_p1;
  logic [3:0] green_p1;
  logic [3:0] blue_p1;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      hs_n_p1  <= 1'b1;
      vs_n_p1  <= 1'b1;
      red_p1   <= 4'h0;
      green_p1 <= 4'h0;
      blue_p1  <= 4'h0;
    end else if (vld_p0) begin
      hs_n_p1  <= hs_n_p0;
      vs_n_p1  <= vs_n_p0;
      red_p1   <= blank(pixel_red_in, video_on_p0);
      green_p1 <= blank(pixel_green_in, video_on_p0);
      blue_p1  <= blank(pixel_blue_in, video_on_p0);
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count_p1;

  always_ff @(posedge clock_in) begin
    if (reset_in)                             frame_count_p1 <= 16'h0;
    else if (vld_p0 && x_last_p0 && y_last_p0) frame_count_p1 <= frame_count_p1 + 16'h1;
  end

  assign frame_count_out = frame_count_p1;
`endif

  assign pixel_x_out     = x_p0;
  assign pixel_y_out     = y_p0;
  assign pixel_tick_out  = vld_p0;
  assign video_on_out    = video_on_p0;
  assign frame_start_out = vld_p0 && x_last_p0 && y_last_p0;
  assign h_sync_out      = hs_n_p1;
  assign v_sync_out      = vs_n_p1;
  assign vga_red_out     = red_p1;
  assign vga_green_out   = green_p1;
  assign vga_blue_out    = blue_p1;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Scoreboard bench for vga_sync_generator on a shrunken raster; the model works from tick number arithmetic.
module tb_vga_sync_generator;

  localparam int CD = 2;
  localparam int HD = 16, HF = 4, HS = 6, HB = 4;
  localparam int VD = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] red_in, green_in, blue_in;
  logic [9:0] x_out, y_out;
  logic       tick, von, fs, hs, vs;
  logic [3:0] r_out, g_out, b_out;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fc_out;
`endif

  always #5 clk = ~clk;

  vga_sync_generator #(
    .WIDTH_BITS(10), .HEIGHT_BITS(10), .CLOCK_DIVIDER(CD),
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
`ifdef VGA_FRAME_COUNT_EN
    .frame_count_out(fc_out),
`endif
    .clock_in(clk), .reset_in(rst),
    .pixel_red_in(red_in), .pixel_green_in(green_in), .pixel_blue_in(blue_in),
    .pixel_x_out(x_out), .pixel_y_out(y_out), .pixel_tick_out(tick),
    .video_on_out(von), .frame_start_out(fs),
    .h_sync_out(hs), .v_sync_out(vs),
    .vga_red_out(r_out), .vga_green_out(g_out), .vga_blue_out(b_out)
  );

  typedef struct {
    logic [31:0] coord;
    logic [31:0] sync;
    logic [31:0] rgb;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   sb_on  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Expected view of pixel number n: raster position by division, sync/blank windows by range
  function automatic exp_t model(input int n, input logic [11:0] rgb_in, input int fc);
    exp_t e;
    int x = n % HT;
    int y = (n / HT) % VT;
    bit vis = (x < HD) && (y < VD);
    bit fsb = (x == HT - 1) && (y == VT - 1);
    bit hsb = !((x >= HD + HF) && (x < HD + HF + HS));
    bit vsb = !((y >= VD + VF) && (y < VD + VF + VS));
    e.coord = (x << 16) | (y << 2) | (int'(fsb) << 1) | int'(vis);
    e.sync  = (int'(hsb) << 1) | int'(vsb);
    e.rgb   = vis ? {20'h0, rgb_in} : 32'h0;
    e.fc    = fc;
    return e;
  endfunction

  function automatic bit is_frame_end(input int n);
    return ((n % HT) == HT - 1) && (((n / HT) % VT) == VT - 1);
  endfunction

  // Monitor: sample coordinates before a tick edge, compare the connector after it
  initial begin
    logic [31:0] a_coord;
    int gap = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!sb_on) begin
        gap = 0;
      end else if (!tick) begin
        gap++;
      end else begin
        chk("tick_gap", gap, CD - 1);
        gap = 0;
        a_coord = (int'(x_out) << 16) | (int'(y_out) << 2) | (int'(fs) << 1) | int'(von);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
          chk("queue_empty_on_tick", 1, 0);
        end else begin
          e = q.pop_front();
          chk("coord_xy_fs_von", a_coord, e.coord);
          chk("sync_hv", {30'h0, hs, vs}, e.sync);
          chk("rgb", {20'h0, r_out, g_out, b_out}, e.rgb);
`ifdef VGA_FRAME_COUNT_EN
          chk("frame_count", {16'h0, fc_out}, e.fc);
`endif
        end
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_xy"}, {12'h0, x_out, y_out}, 32'h0);
    chk({tag, "_sync"}, {30'h0, hs, vs}, 32'h3);
    chk({tag, "_rgb"}, {20'h0, r_out, g_out, b_out}, 32'h0);
    chk({tag, "_fs"}, {31'h0, fs}, 32'h0);
    chk({tag, "_von"}, {31'h0, von}, 32'h1);
    if (CD > 1) chk({tag, "_tick"}, {31'h0, tick}, 32'h0);
`ifdef VGA_FRAME_COUNT_EN
    chk({tag, "_fc"}, {16'h0, fc_out}, 32'h0);
`endif
  endtask

  // Driver: choose pixel inputs just after each edge and queue the expectation for the coming tick
  initial begin
    int n = 0;
    int fcm = 0;
    bit did_mid = 1'b0;
    bit done = 1'b0;
    logic [11:0] rgb;
    rst = 1'b1;
    red_in = 4'h0; green_in = 4'h0; blue_in = 4'h0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    chk_reset_state("reset");
    sb_on = 1'b1;
    for (int c = 0; c < 20000 && !done; c++) begin
      if (!did_mid && n < FRAME) rgb = 12'hAAA;
      else                       rgb = 12'($urandom);
      {red_in, green_in, blue_in} = rgb;
      if (tick) begin
        if (!did_mid && n == 2 * FRAME + 11 * HT + 22) begin
          rst = 1'b1;
          sb_on = 1'b0;
          @(posedge clk);
          #2;
          chk_reset_state("mid_reset");
          rst = 1'b0;
          n = 0;
          fcm = 0;
          did_mid = 1'b1;
          sb_on = 1'b1;
        end else begin
          if (is_frame_end(n)) fcm = (fcm + 1) & 32'hFFFF;
          q.push_back(model(n, rgb, fcm));
          n++;
          if (did_mid && n >= 3 * FRAME + 40) done = 1'b1;
        end
      end
      @(posedge clk);
      #2;
    end
    sb_on = 1'b0;
    if (!done) chk("run_budget_expired", 0, 1);
    repeat (4) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
